// File: rtl/data_sync_mc.sv
// data_sync_mc: NUM_CH independent enable-qualified bus synchronisers, each exposing a valid/ready word.
// Latency: capture NUM_STAGES edges after bus_enable is first sampled high; enable_pulse marks the capture.
// Backpressure: never stalls; a new word overwrites an unconsumed one and sets sticky overrun. DATA_SYNC_TOGGLE_EN selects toggle events.
module data_sync_mc #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           sync_ready,
    input  logic [NUM_CH-1:0]           overrun_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           sync_valid,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           overrun
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_STAGES-1:0] sync;
        logic                  pg;
        logic                  evt;
        logic                  valid_q;
        logic                  pulse_q;
        logic                  ovr_q;
        logic [BUS_WIDTH-1:0]  bus_q;

`ifdef DATA_SYNC_TOGGLE_EN
        assign evt = sync[NUM_STAGES-1] ^ pg;
`else
        assign evt = sync[NUM_STAGES-1] & ~pg;
`endif

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync    <= '0;
                pg      <= 1'b0;
                bus_q   <= '0;
                valid_q <= 1'b0;
                pulse_q <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                sync    <= {sync[NUM_STAGES-2:0], bus_enable[i]};
                pg      <= sync[NUM_STAGES-1];
                pulse_q <= evt;
                if (evt) begin
                    bus_q   <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
                    valid_q <= 1'b1;
                end else if (sync_ready[i]) begin
                    valid_q <= 1'b0;
                end
                // A capture on the same edge as a transfer replaces a consumed word, not an unread one.
                if (evt && valid_q && !sync_ready[i]) begin
                    ovr_q <= 1'b1;
                end else if (overrun_clr[i]) begin
                    ovr_q <= 1'b0;
                end
            end
        end

        assign sync_bus[i*BUS_WIDTH +: BUS_WIDTH] = bus_q;
        assign sync_valid[i]                      = valid_q;
        assign enable_pulse[i]                    = pulse_q;
        assign overrun[i]                         = ovr_q;
    end

endmodule

// File: tb/tb_data_sync_mc.sv
// Testbench for data_sync_mc: directed scenarios plus randomized traffic against a sample-history reference model.
module tb_data_sync_mc;
    localparam int BW = 8;
    localparam int NS = 2;
    localparam int NC = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NC-1:0]    bus_enable;
    logic [NC*BW-1:0] unsync_bus;
    logic [NC-1:0]    sync_ready;
    logic [NC-1:0]    overrun_clr;
    logic [NC*BW-1:0] sync_bus;
    logic [NC-1:0]    sync_valid;
    logic [NC-1:0]    enable_pulse;
    logic [NC-1:0]    overrun;

    int n_pass = 0;
    int n_total = 0;

    data_sync_mc #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .NUM_CH(NC)) dut (
        .CLK(CLK), .RST(RST), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(sync_bus),
        .sync_valid(sync_valid), .enable_pulse(enable_pulse), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_data(input int c, input logic [BW-1:0] d);
        unsync_bus[c*BW +: BW] = d;
    endtask

    // Reference model: hist[c][j] is the enable sample taken j+1 edges ago (0 for samples at/before reset).
    bit            hist   [NC][NS+1];
    logic [BW-1:0] exp_q  [NC][$];
    logic [BW-1:0] m_bus  [NC];
    bit            m_pulse[NC];
    bit            m_ovr  [NC];

    initial begin
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j <= NS; j++) hist[c][j] = 1'b0;
            m_bus[c] = '0; m_pulse[c] = 1'b0; m_ovr[c] = 1'b0;
        end
    end

    always @(posedge CLK) begin
        for (int c = 0; c < NC; c++) begin
            if (RST) begin
                for (int j = 0; j <= NS; j++) hist[c][j] = 1'b0;
                exp_q[c].delete();
                m_bus[c] = '0; m_pulse[c] = 1'b0; m_ovr[c] = 1'b0;
            end else begin
                bit now_s, prev_s, ev, pending, set_ovr;
                now_s  = hist[c][NS-1];
                prev_s = hist[c][NS];
`ifdef DATA_SYNC_TOGGLE_EN
                ev = now_s != prev_s;
`else
                ev = now_s && !prev_s;
`endif
                pending = exp_q[c].size() != 0;
                set_ovr = ev && pending && !sync_ready[c];
                if (ev) begin
                    if (pending) void'(exp_q[c].pop_back());
                    exp_q[c].push_back(unsync_bus[c*BW +: BW]);
                    m_bus[c] = unsync_bus[c*BW +: BW];
                end
                m_pulse[c] = ev;
                if (set_ovr) m_ovr[c] = 1'b1;
                else if (overrun_clr[c]) m_ovr[c] = 1'b0;
                for (int j = NS; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = bus_enable[c];
            end
        end
    end

    // Monitor: compares visible state each cycle and pops the scoreboard on every transfer.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("sb_valid%0d", c), 32'(sync_valid[c]), 32'(exp_q[c].size() != 0));
                chk($sformatf("sb_pulse%0d", c), 32'(enable_pulse[c]), 32'(m_pulse[c]));
                chk($sformatf("sb_ovr%0d", c), 32'(overrun[c]), 32'(m_ovr[c]));
                chk($sformatf("sb_bus%0d", c), 32'(sync_bus[c*BW +: BW]), 32'(m_bus[c]));
                if (sync_valid[c] && sync_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("sb_xfer_unexpected%0d", c), 32'(1), 32'(0));
                    end else begin
                        logic [BW-1:0] w;
                        w = exp_q[c].pop_front();
                        chk($sformatf("sb_xfer%0d", c), 32'(sync_bus[c*BW +: BW]), 32'(w));
                    end
                end
            end
        end
    end

    int hold[NC];

    initial begin
        RST = 1'b1; sync_ready = '0; overrun_clr = '0; unsync_bus = '0;
`ifndef DATA_SYNC_TOGGLE_EN
        bus_enable = '1;
        set_data(0, 8'hA5); set_data(1, 8'h5A);
        step(2);
        chk("rst_outputs", {sync_valid, enable_pulse, overrun, 16'(sync_bus)}, 32'h0);
        RST = 1'b0;
        step(2);
        chk("rst_pulse_early", 32'(enable_pulse[0]), 32'h0);
        step(1);
        chk("rst_pulse", 32'(enable_pulse[0]), 32'h1);
        chk("rst_bus", 32'(sync_bus[7:0]), 32'hA5);
        step(1);
        chk("rst_pulse_one", 32'(enable_pulse[0]), 32'h0);
        sync_ready = '1; bus_enable = '0;
        step(3);
        // single transfer on ch1
        set_data(1, 8'h3C); bus_enable[1] = 1'b1;
        step(3);
        chk("xfer_valid", 32'(sync_valid[1]), 32'h1);
        chk("xfer_bus", 32'(sync_bus[15:8]), 32'h3C);
        chk("xfer_ch0", 32'(sync_valid[0]), 32'h0);
        step(1);
        chk("xfer_drop", 32'(sync_valid[1]), 32'h0);
        chk("xfer_hold", 32'(sync_bus[15:8]), 32'h3C);
        bus_enable[1] = 1'b0;
        // overrun on ch0
        sync_ready[0] = 1'b0;
        set_data(0, 8'h11); bus_enable[0] = 1'b1; step(3);
        bus_enable[0] = 1'b0; step(3);
        set_data(0, 8'h22); bus_enable[0] = 1'b1; step(3);
        chk("ovr_bus", 32'(sync_bus[7:0]), 32'h22);
        chk("ovr_valid", 32'(sync_valid[0]), 32'h1);
        chk("ovr_set", 32'(overrun[0]), 32'h1);
        bus_enable[0] = 1'b0;
        overrun_clr[0] = 1'b1; step(1); overrun_clr[0] = 1'b0;
        chk("ovr_clr", 32'(overrun[0]), 32'h0);
        step(2);
        set_data(0, 8'h33); bus_enable[0] = 1'b1; step(2);
        overrun_clr[0] = 1'b1; step(1); overrun_clr[0] = 1'b0;
        chk("ovr_set_wins", 32'(overrun[0]), 32'h1);
        chk("ovr_bus33", 32'(sync_bus[7:0]), 32'h33);
        bus_enable[0] = 1'b0; step(3);
        overrun_clr[0] = 1'b1; step(1); overrun_clr[0] = 1'b0;
        // capture coinciding with transfer
        set_data(0, 8'h44); bus_enable[0] = 1'b1; step(2);
        sync_ready[0] = 1'b1; step(1);
        chk("coin_valid", 32'(sync_valid[0]), 32'h1);
        chk("coin_bus", 32'(sync_bus[7:0]), 32'h44);
        chk("coin_ovr", 32'(overrun[0]), 32'h0);
        bus_enable[0] = 1'b0; step(3);
        // reset mid-flight
        set_data(0, 8'h55); bus_enable[0] = 1'b1; step(1);
        RST = 1'b1; step(1); RST = 1'b0;
        chk("mid_valid", 32'(sync_valid), 32'h0);
        step(2);
        chk("mid_pulse_early", 32'(enable_pulse[0]), 32'h0);
        step(1);
        chk("mid_pulse", 32'(enable_pulse[0]), 32'h1);
        chk("mid_bus", 32'(sync_bus[7:0]), 32'h55);
        bus_enable[0] = 1'b0; step(3);
`else
        bus_enable = '0;
        step(2);
        chk("rst_outputs", {sync_valid, enable_pulse, overrun, 16'(sync_bus)}, 32'h0);
        RST = 1'b0; sync_ready = '1;
        step(1);
        set_data(0, 8'h01); bus_enable[0] = 1'b1; step(3);
        chk("tog_pulse1", 32'(enable_pulse[0]), 32'h1);
        chk("tog_bus1", 32'(sync_bus[7:0]), 32'h01);
        step(1);
        chk("tog_pulse1_one", 32'(enable_pulse[0]), 32'h0);
        step(2);
        set_data(0, 8'h02); bus_enable[0] = 1'b0; step(3);
        chk("tog_pulse2", 32'(enable_pulse[0]), 32'h1);
        chk("tog_bus2", 32'(sync_bus[7:0]), 32'h02);
        chk("tog_ovr", 32'(overrun[0]), 32'h0);
        step(3);
`endif
        // randomized traffic, enable held >= 3 cycles per level
        for (int c = 0; c < NC; c++) hold[c] = $urandom_range(3, 7);
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                sync_ready[c]  = ($urandom_range(0, 9) < 7);
                overrun_clr[c] = ($urandom_range(0, 9) == 0);
                hold[c]--;
                if (hold[c] == 0) begin
                    bus_enable[c] = ~bus_enable[c];
                    set_data(c, BW'($urandom));
                    hold[c] = $urandom_range(3, 7);
                end
            end
            if ($urandom_range(0, 199) == 0) RST = 1'b1;
            else RST = 1'b0;
            step(1);
        end
        RST = 1'b0; bus_enable = '0; sync_ready = '1; overrun_clr = '0;
        step(8);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
- Multi-channel successor to the single-bus MCP data synchroniser.
- Sits in the destination clock domain and carries NUM_CH independent multi-bit buses from a foreign domain. Each bus is qualified by its own enable, which passes through an N-stage synchroniser.
- Each channel captures its bus on the synchronised enable event and exposes a stream with valid/ready and sticky overrun detection.
- Channels never interact. All logic runs on CLK.

Parameters:
- BUS_WIDTH, 8, width of each channel's data bus.
- NUM_STAGES, 2, depth of the enable synchroniser chain; legal values are >= 2.
- NUM_CH, 2, number of independent channels; legal values are >= 1.

Ports:
- CLK  in  1  destination-domain clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- bus_enable  in  NUM_CH  per-channel enable from the source domain; bit i belongs to channel i.
- unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel i uses slice [i*BUS_WIDTH +: BUS_WIDTH]. The source holds it stable from before the enable event until capture.
- sync_ready  in  NUM_CH  consumer ready, per channel.
- overrun_clr  in  NUM_CH  per-channel clear of the sticky overrun flag.
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data; same slicing as unsync_bus.
- sync_valid  out  NUM_CH  captured word pending, per channel.
- enable_pulse  out  NUM_CH  one-cycle pulse coincident with each capture.
- overrun  out  NUM_CH  sticky flag: a word was overwritten before it was consumed.

Behaviour:
- Interface decision: one clock (CLK); reset RST is synchronous and active-high.
- Reset (RST=1 at a rising edge) clears the following, for all channels:
  - sync chain, pulse-gen FF, sync_bus, sync_valid, enable_pulse and overrun all go to 0.
  - Reset asserted mid-operation discards any in-flight event and any pending word.
- Per-channel synchroniser:
  - sync[0] <= bus_enable[i]; sync[k] <= sync[k-1].
  - pg <= sync[NUM_STAGES-1].
- Event detection (combinational, from the registered chain):
  - Level mode (default): event = sync[NUM_STAGES-1] & ~pg, i.e. the rising edge of the enable.
  - Toggle mode: see Optional Feature.
- Capture: on the edge where event=1:
  - sync_bus slice <= unsync_bus slice.
  - enable_pulse <= 1 for exactly one cycle; otherwise enable_pulse <= 0.
  - sync_valid <= 1.
- Latency:
  - bus_enable first sampled high at edge k gives capture at edge k+NUM_STAGES.
  - For NUM_STAGES=2, sync_valid and data are visible after the third edge.
  - One event per enable edge; holding the enable high gives no repeat.
- Handshake:
  - A transfer occurs on an edge where sync_valid=1 and sync_ready=1; sync_valid then clears unless a capture happens on the same edge.
  - sync_bus holds its value while no capture occurs, including after a transfer.
- Simultaneous event and transfer on the same edge:
  - The new word loads and sync_valid stays 1.
  - No overrun is flagged.
- Event while sync_valid=1 and sync_ready=0:
  - The new word overwrites the old one and sync_valid stays 1.
  - overrun <= 1 (sticky).
- overrun_clr:
  - overrun_clr=1 clears overrun on that edge.
  - If a new overrun condition occurs on the same edge, set wins and overrun stays 1.
- Minimum enable spacing for lossless operation: the enable must stay low for at least 2 CLK cycles between events. Shorter pulses may be filtered; that case is not required to be detected.
- Channels are fully independent; simultaneous events on all channels are all captured on the same edge.

Optional Feature:
- Macro: DATA_SYNC_TOGGLE_EN.
- Defined: every channel runs in toggle mode.
  - event = sync[NUM_STAGES-1] ^ pg, so each transition of bus_enable (0->1 or 1->0) is one new word.
  - Latency and handshake are identical to level mode.
  - The source must hold bus_enable at 0 through reset. If it is 1 at reset release, one event is generated NUM_STAGES+1 edges later, and that is the required behaviour.
- Undefined: level mode as described in Behaviour; a falling edge produces no event.

Test Plan:
- Reset/idle: RST=1 for 2 edges with bus_enable=all 1 -> all outputs 0 during reset. After release, ch0 captures unsync_bus=0xA5 exactly 3 edges later (NUM_STAGES=2) with enable_pulse=1 for one cycle.
- Single transfer: ch1 enable rises with data 0x3C and sync_ready=1 -> sync_valid=1 for one cycle, sync_bus ch1=0x3C, which is held after sync_valid drops; ch0 outputs unchanged.
- Overrun: ch0 sync_ready=0; two enable pulses carry 0x11 then 0x22 -> sync_bus=0x22, sync_valid=1, overrun=1. overrun_clr pulse -> overrun=0. A new overrun on the clr edge -> overrun stays 1.
- Capture coinciding with transfer: sync_ready=1 on the capture edge of a second word -> sync_valid stays 1 with the new data and overrun stays 0.
- Reset mid-flight: RST asserted one edge after bus_enable rises -> no capture, sync_valid=0. With bus_enable still high after release, capture occurs NUM_STAGES+1 edges after release.
- Toggle mode (DATA_SYNC_TOGGLE_EN): bus_enable toggles 0->1->0 with data 0x01 then 0x02, 6 cycles apart -> two captures, values 0x01 and 0x02, two enable_pulse cycles, no overrun with sync_ready=1.
